// File: rtl/ide_pkg.sv
// ide_pkg: shared types and timing defaults for the IDE PIO sequencer.
// Phase counters are IDE_PHASE_W bits wide.
package ide_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACTIVE,
        HOLD,
        RECOVER
    } ide_pio_state_t;

    localparam int IDE_PHASE_W           = 4;
    localparam int IDE_PHASE_MAX         = (1 << IDE_PHASE_W) - 1;
    localparam int IDE_T_SETUP_DEF       = 1;
    localparam int IDE_T_ACTIVE_DEF      = 3;
    localparam int IDE_T_RECOVERY_DEF    = 2;
    localparam int IDE_IORDY_TIMEOUT_DEF = 12;

    // A phase of n cycles loads n-1 and ends on the cycle the count is zero.
    function automatic logic [IDE_PHASE_W-1:0] ide_phase_load(input int n);
        return IDE_PHASE_W'(n - 1);
    endfunction

endpackage

// File: rtl/ide_phase_timer.sv
// ide_phase_timer: loadable down-counter that saturates at zero.
// zero_o reflects the registered count.
module ide_phase_timer
    import ide_pkg::*;
(
    input  logic                   CLK,
    input  logic                   n_reset_clocked,
    input  logic                   load_i,
    input  logic [IDE_PHASE_W-1:0] val_i,
    input  logic                   dec_i,
    output logic                   zero_o
);

    logic [IDE_PHASE_W-1:0] cnt_q;
    logic [IDE_PHASE_W-1:0] cnt_d;

    // load wins over decrement; the count never wraps below zero
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // count register
    always_ff @(posedge CLK or negedge n_reset_clocked) begin
        if (!n_reset_clocked) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ide_pio_sequencer.sv
// ide_pio_sequencer: turns 68000 accesses to $DA0000-$DA3FFF into timed
// ATA PIO cycles. IORDY wait states are built only with IDE_PIO_IORDY_WAIT_EN.
module ide_pio_sequencer
    import ide_pkg::*;
#(
    parameter int T_SETUP       = IDE_T_SETUP_DEF,
    parameter int T_ACTIVE      = IDE_T_ACTIVE_DEF,
    parameter int T_RECOVERY    = IDE_T_RECOVERY_DEF,
    parameter int IORDY_TIMEOUT = IDE_IORDY_TIMEOUT_DEF
) (
    input  logic CLK,
    input  logic n_reset_clocked,
    input  logic _AS,
    input  logic R_W,
    input  logic ide_sel,
    input  logic IORDY,
    output logic _DIOR,
    output logic _DIOW,
    output logic dd_oe,
    output logic rd_latch,
    output logic dtack_en,
    output logic busy,
    output logic timeout
);

    localparam logic [IDE_PHASE_W-1:0] LD_SETUP = ide_phase_load(T_SETUP);
    localparam logic [IDE_PHASE_W-1:0] LD_ACT   = ide_phase_load(T_ACTIVE);
    localparam logic [IDE_PHASE_W-1:0] LD_REC   = ide_phase_load(T_RECOVERY);

    if (T_SETUP < 1 || T_SETUP > IDE_PHASE_MAX) begin : g_bad_setup
        $error("T_SETUP must be 1..15");
    end
    if (T_ACTIVE < 1 || T_ACTIVE > IDE_PHASE_MAX) begin : g_bad_active
        $error("T_ACTIVE must be 1..15");
    end
    if (T_RECOVERY < 1 || T_RECOVERY > IDE_PHASE_MAX) begin : g_bad_rec
        $error("T_RECOVERY must be 1..15");
    end
    if (IORDY_TIMEOUT < 1 || IORDY_TIMEOUT > IDE_PHASE_MAX) begin : g_bad_tmo
        $error("IORDY_TIMEOUT must be 1..15");
    end

    ide_pio_state_t state_q;
    ide_pio_state_t state_d;

    logic                   as_s_q;
    logic                   dir_q;
    logic                   dir_d;
    logic                   dior_q;
    logic                   diow_q;
    logic                   oe_q;
    logic                   dtack_q;
    logic                   busy_q;
    logic                   timeout_q;
    logic                   timeout_d;
    logic                   ph_ld;
    logic [IDE_PHASE_W-1:0] ph_val;
    logic                   ph_zero;
    logic                   act_done;
    logic                   tmo_hit;

    ide_phase_timer u_phase (
        .CLK             (CLK),
        .n_reset_clocked (n_reset_clocked),
        .load_i          (ph_ld),
        .val_i           (ph_val),
        .dec_i           (1'b1),
        .zero_o          (ph_zero)
    );

`ifdef IDE_PIO_IORDY_WAIT_EN
    logic wt_zero;
    logic wt_dec;

    // the wait budget is rearmed whenever the strobe is not active
    assign wt_dec = (state_q == ACTIVE) && ph_zero && !IORDY;

    ide_phase_timer u_wait (
        .CLK             (CLK),
        .n_reset_clocked (n_reset_clocked),
        .load_i          (state_q != ACTIVE),
        .val_i           (IDE_PHASE_W'(IORDY_TIMEOUT)),
        .dec_i           (wt_dec),
        .zero_o          (wt_zero)
    );

    assign act_done = ph_zero && (IORDY || wt_zero);
    assign tmo_hit  = ph_zero && !IORDY && wt_zero;
`else
    logic unused_iordy;

    assign unused_iordy = IORDY;
    assign act_done     = ph_zero;
    assign tmo_hit      = 1'b0;
`endif

    // next state, latched direction, phase loads and sticky timeout
    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        ph_ld     = 1'b0;
        ph_val    = '0;
        timeout_d = timeout_q;
        unique case (state_q)
            IDLE: begin
                if (!as_s_q && ide_sel) begin
                    state_d   = SETUP;
                    dir_d     = R_W;
                    ph_ld     = 1'b1;
                    ph_val    = LD_SETUP;
                    timeout_d = 1'b0;
                end
            end
            SETUP: begin
                if (as_s_q) begin
                    state_d = RECOVER;
                    ph_ld   = 1'b1;
                    ph_val  = LD_REC;
                end else if (ph_zero) begin
                    state_d = ACTIVE;
                    ph_ld   = 1'b1;
                    ph_val  = LD_ACT;
                end
            end
            ACTIVE: begin
                if (as_s_q) begin
                    state_d = RECOVER;
                    ph_ld   = 1'b1;
                    ph_val  = LD_REC;
                end else if (act_done) begin
                    state_d   = HOLD;
                    timeout_d = tmo_hit;
                end
            end
            HOLD: begin
                if (as_s_q) begin
                    state_d = RECOVER;
                    ph_ld   = 1'b1;
                    ph_val  = LD_REC;
                end
            end
            RECOVER: begin
                if (ph_zero) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state, bus-strobe sync and outputs registered from the next state
    always_ff @(posedge CLK or negedge n_reset_clocked) begin
        if (!n_reset_clocked) begin
            state_q   <= IDLE;
            as_s_q    <= 1'b1;
            dir_q     <= 1'b0;
            dior_q    <= 1'b1;
            diow_q    <= 1'b1;
            oe_q      <= 1'b0;
            dtack_q   <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            as_s_q    <= _AS;
            dir_q     <= dir_d;
            dior_q    <= !((state_d == ACTIVE) && dir_d);
            diow_q    <= !((state_d == ACTIVE) && !dir_d);
            oe_q      <= !dir_d &&
                         (state_d inside {SETUP, ACTIVE, HOLD});
            dtack_q   <= (state_d == HOLD);
            busy_q    <= (state_d != IDLE);
            timeout_q <= timeout_d;
        end
    end

    assign _DIOR    = dior_q;
    assign _DIOW    = diow_q;
    assign dd_oe    = oe_q;
    assign dtack_en = dtack_q;
    assign busy     = busy_q;
    assign timeout  = timeout_q;

    // capture strobe: last ACTIVE cycle of a read that is not being aborted
    assign rd_latch = (state_q == ACTIVE) && act_done && dir_q && !as_s_q;

endmodule

// File: doc/ide_pio_sequencer.md
Name: ide_pio_sequencer

Overview:
- Sequences 68000 accesses to the IDE task-file window $DA0000-$DA3FFF into timed ATA PIO cycles: address setup, strobe active, data capture, hold, recovery.
- Drives the _DIOR/_DIOW strobes and the data-buffer controls. Returns a DTACK-enable to the CPU bus interface.
- Sits between the address decode/DA/_CS latch logic and the IDE connector. Replaces the fixed one-clock strobe delay with programmable phase lengths.

Parameters:
- T_SETUP, 1, CLK cycles from cycle start to strobe assertion (1..15).
- T_ACTIVE, 3, CLK cycles strobe held low (1..15).
- T_RECOVERY, 2, CLK cycles strobes high before the next cycle may start (1..15).
- IORDY_TIMEOUT, 12, maximum extra ACTIVE cycles while IORDY low (1..15); used only with the optional feature.

Ports:
- CLK  in  1  CPU clock; all state changes on rising edge.
- n_reset_clocked  in  1  asynchronous active-low reset.
- _AS  in  1  68000 address strobe, raw.
- R_W  in  1  68000 read/write; high = read.
- ide_sel  in  1  decoded hit on $DA0000-$DA3FFF; valid while _AS low.
- IORDY  in  1  IDE ready; ignored unless IORDY_WAIT_EN.
- _DIOR  out  1  IDE read strobe, active low.
- _DIOW  out  1  IDE write strobe, active low.
- dd_oe  out  1  drive CPU data onto IDE bus (write cycles).
- rd_latch  out  1  one-cycle pulse; capture DDIN into the CPU read latch.
- dtack_en  out  1  request DTACK to the CPU for this cycle.
- busy  out  1  sequencer not in IDLE.
- timeout  out  1  sticky; last cycle ended by IORDY timeout.

Behaviour:
- Reset: n_reset_clocked is asynchronous, active-low; clock is CLK.
- While in reset: state IDLE, _DIOR=_DIOW=1, dd_oe=0, rd_latch=0, dtack_en=0, busy=0, timeout=0, counters=0.
- as_s is _AS registered once on CLK; all decisions use as_s, never raw _AS.
- States: IDLE, SETUP, ACTIVE, HOLD, RECOVER.
- IDLE -> SETUP when as_s=0 and ide_sel=1.
  - Latch R_W into dir; dir stays fixed for the whole cycle.
  - Load counter with T_SETUP-1.
  - Clear timeout.
- SETUP:
  - Strobes high.
  - dd_oe = !dir.
  - On counter=0 -> ACTIVE, load T_ACTIVE-1.
- ACTIVE:
  - _DIOR = !dir; _DIOW = dir.
  - dd_oe = !dir.
  - On counter=0 -> HOLD.
  - rd_latch = dir in the final ACTIVE cycle, exactly one pulse per read.
- HOLD:
  - Strobes high.
  - dtack_en=1.
  - dd_oe stays asserted for writes.
  - Exit when as_s=1 -> RECOVER, load T_RECOVERY-1; dtack_en=0 and dd_oe=0 in the same cycle.
- RECOVER: all outputs inactive; on counter=0 -> IDLE.
  - A pending as_s=0 with ide_sel is not accepted until IDLE.
  - Earliest restart is one cycle after the RECOVER exit.
- Latency for a read with defaults: strobe low from cycle-start+1 for 3 cycles. rd_latch on cycle-start+3. dtack_en from cycle-start+4.
- Abort: as_s=1 while in SETUP or ACTIVE -> RECOVER on the next edge.
  - Strobes deassert on that edge.
  - No rd_latch, no dtack_en.
- ide_sel dropping mid-cycle while as_s=0 is ignored; the cycle completes.
- Counters are 4-bit down-counters; a parameter value of 0 is illegal and flagged by a synthesis-time check.
- busy=1 in every state except IDLE.

Optional Feature:
- Macro IDE_PIO_IORDY_WAIT_EN.
- When defined:
  - When the ACTIVE counter reaches 0 and IORDY=0, stay in ACTIVE with the strobe held.
  - Count wait cycles; rd_latch is deferred to the cycle IORDY is seen high.
  - After IORDY_TIMEOUT wait cycles, force HOLD and set timeout=1. For reads, rd_latch still pulses in that final cycle.
- When undefined: IORDY is unused and ACTIVE is always exactly T_ACTIVE cycles; timeout is tied 0.

Decomposition:
- Shared package ide_pkg holds:
  - state enum ide_pio_state_t (IDLE, SETUP, ACTIVE, HOLD, RECOVER);
  - default timing constants IDE_T_SETUP_DEF, IDE_T_ACTIVE_DEF, IDE_T_RECOVERY_DEF, IDE_IORDY_TIMEOUT_DEF;
  - IDE_PHASE_W=4.
- One natural sub-module: ide_phase_timer. It is a loadable 4-bit down-counter with a zero flag, instanced once for phase timing and once for the IORDY wait count.

Test Plan:
- Read, defaults: _AS low with ide_sel=1, R_W=1.
  - Expect _DIOR low for exactly 3 cycles starting 1 cycle after cycle start.
  - Expect rd_latch one pulse in the 3rd low cycle, then dtack_en until _AS high, then 2 RECOVER cycles with busy=1.
- Write, T_SETUP=2 T_ACTIVE=4: R_W=0.
  - Expect dd_oe high from cycle start until _AS rises.
  - Expect _DIOW low for 4 cycles after 2 setup cycles, _DIOR never low, and no rd_latch.
- Abort: raise _AS during the 2nd ACTIVE cycle.
  - Strobe must be high on the next edge.
  - No dtack_en and no rd_latch; go to RECOVER then IDLE.
- Back-to-back: second _AS low arrives during RECOVER.
  - The new SETUP must start only after RECOVER completes.
  - Check the strobe-high gap is ≥ T_RECOVERY+1 cycles.
- Reset mid-cycle: assert n_reset_clocked low during ACTIVE of a read.
  - All outputs go inactive immediately (asynchronous) and the state is IDLE after release.
- IORDY (with IDE_PIO_IORDY_WAIT_EN, IORDY_TIMEOUT=4):
  - IORDY low for 2 extra cycles -> strobe extended 2 cycles, rd_latch on the IORDY-high cycle, timeout=0.
  - IORDY held low -> HOLD after 4 wait cycles with timeout=1.
